// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline-stage buffers: width helpers,
// wrapping pointer increment and stage payload layouts.
package pipe_pkg;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Explicit wrap at depth-1 so non-power-of-two depths index only real slots.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

  // Template stage payload; stages pack this into DATA_W and unpack on the far side.
  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic [31:0] alu_result;
    logic [31:0] read_result;
    logic [31:0] pc_plus_4;
    logic [31:0] imm_ext;
    logic [4:0]  rd;
  } mem_wb_payload_t;

endpackage

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register: DEPTH-entry circular buffer with
// valid/ready on both sides and a synchronous flush that behaves like reset.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned DEPTH         = 2,
  parameter bit          ZERO_ON_FLUSH = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  // Handshake: a word moves on an edge where valid and ready are both high.
  // in_ready depends only on registered count, never on out_ready.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              push;
  logic              pop;

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= PW'(ptr_next(32'(wr_ptr), DEPTH));
      if (pop)  rd_ptr <= PW'(ptr_next(32'(rd_ptr), DEPTH));
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Push and pop slots never coincide: equal pointers mean empty (no pop)
  // or full (no push).
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      if (ZERO_ON_FLUSH) begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end
    end else begin
      if (pop && ZERO_ON_FLUSH) mem[rd_ptr] <= '0;
      if (push) mem[wr_ptr] <= in_data;
    end
  end

endmodule
